// File: rtl/wb_qspi_pkg.sv
// Shared types and helpers for the Wishbone-to-QSPI request path.
// Holds the arbiter state encoding, the request payload struct, the
// ROM/RAM chip-select encoding used by wb_qspi_mem integration, and the
// legal-write byte-enable check.
package wb_qspi_pkg;

   localparam int unsigned ADR_W     = 32;
   localparam int unsigned DAT_W     = 32;
   localparam int unsigned BE_W      = 4;
   localparam int unsigned MEM_ADR_W = 22;

   // Chip-select encoding seen by the memory controller
   localparam logic SEL_ROM = 1'b0;
   localparam logic SEL_RAM = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      LOCAL = 2'd2
   } arb_state_e;

   // One master request as presented on its Wishbone port
   typedef struct packed {
      logic             we;
      logic [BE_W-1:0]  be;
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
   } wb_req_t;

   // Byte-enable patterns the controller can write: single bytes,
   // aligned/centred halfwords and full words.
   function automatic logic be_write_legal(input logic [BE_W-1:0] be);
      logic ok;
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b0110, 4'b1100, 4'b1111: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/wb_arb2_rr.sv
// Two-way request arbiter with a last-grant register.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req            request vector {m1, m0}
//   accept         grant taken this cycle; updates last-grant
//   gnt_valid_c    at least one request present (combinational)
//   gnt_idx_c      winning port index (combinational)
module wb_arb2_rr #(
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       gnt_valid_c,
   output logic       gnt_idx_c
);

   logic last_q;

   // Winner selection; ties go to the port not served last, or to m1
   always_comb begin
      gnt_valid_c = |req;
      gnt_idx_c   = 1'b0;
      case (req)
         2'b01:   gnt_idx_c = 1'b0;
         2'b10:   gnt_idx_c = 1'b1;
         2'b11:   gnt_idx_c = (ROUND_ROBIN != 0) ? ~last_q : 1'b1;
         default: gnt_idx_c = 1'b0;
      endcase
   end

   // Last-grant starts at m1 so the first tie goes to m0
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (accept) begin
         last_q <= gnt_idx_c;
      end
   end

endmodule

// File: rtl/wb_qspi_arb.sv
// Two-master Wishbone arbiter and request sequencer for wb_qspi_mem.
// m0 is instruction fetch, m1 is data. The granted request is latched and
// held on mem_* for the whole QSPI transaction; writes the controller
// cannot perform are completed locally without strobing the controller.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mK_stb/we/be/adr/dat  Wishbone request from master K
//   mK_ack_o, mK_err_o    completion to master K (combinational)
//   mK_dat_o              read data, pass-through of mem_dat_i
//   mem_stb/we/be/adr/dat registered request to the controller
//   mem_sel_rom_ram_o     registered chip select, 0 = ROM, 1 = RAM
//   mem_ack_i, mem_dat_i  controller completion and read data
import wb_qspi_pkg::*;

module wb_qspi_arb #(
   parameter int unsigned RAM_SEL_BIT = 24,
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic                 m0_stb_i,
   input  logic                 m0_we_i,
   input  logic [BE_W-1:0]      m0_be_i,
   input  logic [ADR_W-1:0]     m0_adr_i,
   input  logic [DAT_W-1:0]     m0_dat_i,
   output logic                 m0_ack_o,
   output logic                 m0_err_o,
   output logic [DAT_W-1:0]     m0_dat_o,

   input  logic                 m1_stb_i,
   input  logic                 m1_we_i,
   input  logic [BE_W-1:0]      m1_be_i,
   input  logic [ADR_W-1:0]     m1_adr_i,
   input  logic [DAT_W-1:0]     m1_dat_i,
   output logic                 m1_ack_o,
   output logic                 m1_err_o,
   output logic [DAT_W-1:0]     m1_dat_o,

   output logic                 mem_stb_o,
   output logic                 mem_we_o,
   output logic [BE_W-1:0]      mem_be_o,
   output logic [MEM_ADR_W-1:0] mem_adr_o,
   output logic [DAT_W-1:0]     mem_dat_o,
   output logic                 mem_sel_rom_ram_o,
   input  logic                 mem_ack_i,
   input  logic [DAT_W-1:0]     mem_dat_i
);

   arb_state_e           state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 err_q, err_d;
   logic                 stb_d, we_d, sel_d;
   logic [BE_W-1:0]      be_d;
   logic [MEM_ADR_W-1:0] adr_d;
   logic [DAT_W-1:0]     dat_d;

   logic    gnt_valid_c, gnt_idx_c, accept_c;
   wb_req_t req0_c, req1_c, req_sel_c;
   logic    unused_adr_bits;

   assign req0_c    = {m0_we_i, m0_be_i, m0_adr_i, m0_dat_i};
   assign req1_c    = {m1_we_i, m1_be_i, m1_adr_i, m1_dat_i};
   assign req_sel_c = gnt_idx_c ? req1_c : req0_c;
   assign accept_c  = (state_q == IDLE) && gnt_valid_c;

   // Only the word address and region bit reach the controller
   assign unused_adr_bits = ^{req_sel_c.adr[ADR_W-1:MEM_ADR_W+2], req_sel_c.adr[1:0]};

   wb_arb2_rr #(
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req         ({m1_stb_i, m0_stb_i}),
      .accept      (accept_c),
      .gnt_valid_c (gnt_valid_c),
      .gnt_idx_c   (gnt_idx_c)
   );

   // Next-state and next request-register values
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      err_d   = err_q;
      stb_d   = mem_stb_o;
      we_d    = mem_we_o;
      be_d    = mem_be_o;
      adr_d   = mem_adr_o;
      dat_d   = mem_dat_o;
      sel_d   = mem_sel_rom_ram_o;

      case (state_q)
         IDLE: begin
            if (gnt_valid_c) begin
               grant_d = gnt_idx_c;
               we_d    = req_sel_c.we;
               be_d    = req_sel_c.be;
               adr_d   = req_sel_c.adr[MEM_ADR_W+1:2];
               dat_d   = req_sel_c.dat;
               sel_d   = req_sel_c.adr[RAM_SEL_BIT];
               // ROM check comes first so a ROM write with be=0 still errors
               if (req_sel_c.we && (req_sel_c.adr[RAM_SEL_BIT] == SEL_ROM)) begin
                  state_d = LOCAL;
                  err_d   = 1'b1;
               end else if (req_sel_c.we && (req_sel_c.be == '0)) begin
                  state_d = LOCAL;
                  err_d   = 1'b0;
               end else if (req_sel_c.we && !be_write_legal(req_sel_c.be)) begin
                  state_d = LOCAL;
                  err_d   = 1'b1;
               end else begin
                  state_d = XFER;
                  err_d   = 1'b0;
                  stb_d   = 1'b1;
               end
            end
         end
         XFER: begin
            // Drop the strobe on the ack edge so the controller sees it low next cycle
            if (mem_ack_i) begin
               stb_d   = 1'b0;
               state_d = IDLE;
            end
         end
         LOCAL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            stb_d   = 1'b0;
         end
      endcase
   end

   // State and held request registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q           <= IDLE;
         grant_q           <= 1'b0;
         err_q             <= 1'b0;
         mem_stb_o         <= 1'b0;
         mem_we_o          <= 1'b0;
         mem_be_o          <= '0;
         mem_adr_o         <= '0;
         mem_dat_o         <= '0;
         mem_sel_rom_ram_o <= SEL_ROM;
      end else begin
         state_q           <= state_d;
         grant_q           <= grant_d;
         err_q             <= err_d;
         mem_stb_o         <= stb_d;
         mem_we_o          <= we_d;
         mem_be_o          <= be_d;
         mem_adr_o         <= adr_d;
         mem_dat_o         <= dat_d;
         mem_sel_rom_ram_o <= sel_d;
      end
   end

   // Completion routing: controller ack in XFER is forwarded in the same cycle
   logic xfer_done_c, local_done_c, done_c;
   assign xfer_done_c  = (state_q == XFER) && mem_ack_i;
   assign local_done_c = (state_q == LOCAL);
   assign done_c       = xfer_done_c || local_done_c;

   assign m0_ack_o = done_c && !grant_q;
   assign m1_ack_o = done_c &&  grant_q;
   assign m0_err_o = local_done_c && err_q && !grant_q;
   assign m1_err_o = local_done_c && err_q &&  grant_q;
   assign m0_dat_o = mem_dat_i;
   assign m1_dat_o = mem_dat_i;

endmodule

// File: tb/tb_wb_qspi_arb.sv
module tb_wb_qspi_arb;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        m0_stb_i = 1'b0, m0_we_i = 1'b0;
   logic [3:0]  m0_be_i = '0;
   logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
   logic        m0_ack_o, m0_err_o;
   logic [31:0] m0_dat_o;
   logic        m1_stb_i = 1'b0, m1_we_i = 1'b0;
   logic [3:0]  m1_be_i = '0;
   logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
   logic        m1_ack_o, m1_err_o;
   logic [31:0] m1_dat_o;
   logic        mem_stb_o, mem_we_o, mem_sel_rom_ram_o;
   logic [3:0]  mem_be_o;
   logic [21:0] mem_adr_o;
   logic [31:0] mem_dat_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_dat_i = '0;

   // Fixed-priority instance sharing the master inputs, with its own responder
   logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
   logic [31:0] fp_m0_dat, fp_m1_dat, fp_mem_dat;
   logic        fp_mem_stb, fp_mem_we, fp_mem_sel;
   logic [3:0]  fp_mem_be;
   logic [21:0] fp_mem_adr;
   logic        fp_mem_ack = 1'b0;
   wire         unused_fp = ^{fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_m0_dat,
                              fp_m1_dat, fp_mem_dat, fp_mem_we, fp_mem_sel, fp_mem_be};

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) fp_mem_ack <= fp_mem_stb & ~fp_mem_ack;

   wb_qspi_arb #(.RAM_SEL_BIT(24), .ROUND_ROBIN(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
      .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
      .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_sel_rom_ram_o(mem_sel_rom_ram_o),
      .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
   );

   wb_qspi_arb #(.RAM_SEL_BIT(24), .ROUND_ROBIN(0)) dut_fp (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err), .m0_dat_o(fp_m0_dat),
      .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err), .m1_dat_o(fp_m1_dat),
      .mem_stb_o(fp_mem_stb), .mem_we_o(fp_mem_we), .mem_be_o(fp_mem_be),
      .mem_adr_o(fp_mem_adr), .mem_dat_o(fp_mem_dat), .mem_sel_rom_ram_o(fp_mem_sel),
      .mem_ack_i(fp_mem_ack), .mem_dat_i(32'h0)
   );

   typedef struct {
      bit          port;
      bit          we;
      logic [3:0]  be;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] rdat;
      bit          is_local;
      bit          err;
      bit          sel;
      logic [21:0] madr;
      string       name;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input bit port, input bit we, input logic [3:0] be,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [31:0] rdat, input bit is_local, input bit err,
                               input bit sel, input logic [21:0] madr, input string name);
      vec_t v;
      v.port = port; v.we = we; v.be = be; v.adr = adr; v.dat = dat; v.rdat = rdat;
      v.is_local = is_local; v.err = err; v.sel = sel; v.madr = madr; v.name = name;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic ack_of(input bit p);
      return p ? m1_ack_o : m0_ack_o;
   endfunction

   function automatic logic err_of(input bit p);
      return p ? m1_err_o : m0_err_o;
   endfunction

   function automatic logic [31:0] dat_of(input bit p);
      return p ? m1_dat_o : m0_dat_o;
   endfunction

   task automatic set_req(input bit p, input bit stb, input bit we, input logic [3:0] be,
                          input logic [31:0] adr, input logic [31:0] dat);
      if (p) begin
         m1_stb_i = stb; m1_we_i = we; m1_be_i = be; m1_adr_i = adr; m1_dat_i = dat;
      end else begin
         m0_stb_i = stb; m0_we_i = we; m0_be_i = be; m0_adr_i = adr; m0_dat_i = dat;
      end
   endtask

   task automatic drop_stb(input bit p);
      if (p) m1_stb_i = 1'b0;
      else   m0_stb_i = 1'b0;
   endtask

   // One isolated transaction: check grant, hold, completion and strobe release
   task automatic run_vec(input vec_t v);
      @(negedge clk_i);
      set_req(v.port, 1'b1, v.we, v.be, v.adr, v.dat);
      @(negedge clk_i);
      if (v.is_local) begin
         chk({v.name, "/no_stb"}, 32'(mem_stb_o), 32'(0));
         chk({v.name, "/ack"}, 32'(ack_of(v.port)), 32'(1));
         chk({v.name, "/err"}, 32'(err_of(v.port)), 32'(v.err));
         chk({v.name, "/other_ack"}, 32'(ack_of(!v.port)), 32'(0));
         drop_stb(v.port);
         @(negedge clk_i);
         chk({v.name, "/no_stb2"}, 32'(mem_stb_o), 32'(0));
         chk({v.name, "/ack_end"}, 32'(ack_of(v.port)), 32'(0));
      end else begin
         chk({v.name, "/stb"}, 32'(mem_stb_o), 32'(1));
         chk({v.name, "/adr"}, 32'(mem_adr_o), 32'(v.madr));
         chk({v.name, "/sel"}, 32'(mem_sel_rom_ram_o), 32'(v.sel));
         chk({v.name, "/we"}, 32'(mem_we_o), 32'(v.we));
         chk({v.name, "/be"}, 32'(mem_be_o), 32'(v.be));
         if (v.we) chk({v.name, "/wdat"}, mem_dat_o, v.dat);
         chk({v.name, "/early_ack"}, 32'(ack_of(v.port)), 32'(0));
         repeat (2) @(negedge clk_i);
         chk({v.name, "/stb_held"}, 32'(mem_stb_o), 32'(1));
         chk({v.name, "/adr_held"}, 32'(mem_adr_o), 32'(v.madr));
         mem_ack_i = 1'b1;
         mem_dat_i = v.rdat;
         #1;
         chk({v.name, "/ack"}, 32'(ack_of(v.port)), 32'(1));
         chk({v.name, "/err"}, 32'(err_of(v.port)), 32'(0));
         chk({v.name, "/other_ack"}, 32'(ack_of(!v.port)), 32'(0));
         chk({v.name, "/rdat"}, dat_of(v.port), v.rdat);
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         drop_stb(v.port);
         chk({v.name, "/stb_drop"}, 32'(mem_stb_o), 32'(0));
         chk({v.name, "/ack_end"}, 32'(ack_of(v.port)), 32'(0));
      end
   endtask

   initial begin
      logic [21:0] bb_madr[2];
      vecs[0] = mk(0, 0, 4'b1111, 32'h0000_0100, 32'h0,         32'h1234_5678, 0, 0, 0, 22'h000040, "m0_rd_rom");
      vecs[1] = mk(1, 1, 4'b1111, 32'h0100_0008, 32'hDEAD_BEEF, 32'h0,         0, 0, 1, 22'h000002, "m1_wr_ram");
      vecs[2] = mk(1, 1, 4'b1111, 32'h0000_0010, 32'h1111_1111, 32'h0,         1, 1, 0, 22'h0,      "m1_wr_rom");
      vecs[3] = mk(1, 1, 4'b0101, 32'h0100_0000, 32'h2222_2222, 32'h0,         1, 1, 1, 22'h0,      "m1_wr_be0101");
      vecs[4] = mk(1, 1, 4'b0000, 32'h0100_0020, 32'h3333_3333, 32'h0,         1, 0, 1, 22'h0,      "m1_wr_be0000");
      vecs[5] = mk(0, 0, 4'b0101, 32'h0100_0004, 32'h0,         32'hA5A5_5A5A, 0, 0, 1, 22'h000001, "m0_rd_be0101");
      vecs[6] = mk(1, 1, 4'b0110, 32'hFF00_0FFF, 32'hCAFE_F00D, 32'h0,         0, 0, 1, 22'h0003FF, "m1_wr_hibits");
      vecs[7] = mk(0, 1, 4'b1100, 32'h0180_0000, 32'h0BAD_F00D, 32'h0,         0, 0, 1, 22'h200000, "m0_wr_be1100");
      vecs[8] = mk(1, 1, 4'b1110, 32'h0100_0010, 32'h4444_4444, 32'h0,         1, 1, 1, 22'h0,      "m1_wr_be1110");
      vecs[9] = mk(0, 0, 4'b0000, 32'h0000_0003, 32'h0,         32'h0F0F_0F0F, 0, 0, 0, 22'h0,      "m0_rd_be0000");

      // Reset values, with a stray controller ack that must not leak out
      mem_ack_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("rst/stb", 32'(mem_stb_o), 32'(0));
      chk("rst/we", 32'(mem_we_o), 32'(0));
      chk("rst/be", 32'(mem_be_o), 32'(0));
      chk("rst/adr", 32'(mem_adr_o), 32'(0));
      chk("rst/dat", mem_dat_o, 32'(0));
      chk("rst/sel", 32'(mem_sel_rom_ram_o), 32'(0));
      chk("rst/acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'(0));
      mem_ack_i = 1'b0;
      rst_i = 1'b0;

      // Controller ack in IDLE is ignored
      @(negedge clk_i);
      mem_ack_i = 1'b1;
      #1;
      chk("idle_ack/acks", 32'({m0_ack_o, m1_ack_o}), 32'(0));
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      chk("idle_ack/stb", 32'(mem_stb_o), 32'(0));

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Asynchronous reset in the middle of a transfer
      @(negedge clk_i);
      set_req(0, 1'b1, 1'b0, 4'b1111, 32'h0000_0200, 32'h0);
      @(negedge clk_i);
      chk("rstx/stb_before", 32'(mem_stb_o), 32'(1));
      #2 rst_i = 1'b1;
      #1;
      chk("rstx/stb_async", 32'(mem_stb_o), 32'(0));
      mem_ack_i = 1'b1;
      #1;
      chk("rstx/no_ack", 32'(m0_ack_o), 32'(0));
      @(negedge clk_i);
      rst_i = 1'b0;
      mem_ack_i = 1'b0;
      @(negedge clk_i);
      chk("rstx/regrant_stb", 32'(mem_stb_o), 32'(1));
      chk("rstx/regrant_adr", 32'(mem_adr_o), 32'(22'h080));
      mem_ack_i = 1'b1;
      mem_dat_i = 32'h7777_8888;
      #1;
      chk("rstx/ack", 32'(m0_ack_o), 32'(1));
      chk("rstx/rdat", m0_dat_o, 32'h7777_8888);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      m0_stb_i = 1'b0;
      chk("rstx/stb_drop", 32'(mem_stb_o), 32'(0));

      // Simultaneous requests from reset (last-grant = m1), then back-to-back
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      bb_madr[0] = 22'h000100;
      bb_madr[1] = 22'h000200;
      set_req(0, 1'b1, 1'b0, 4'b1111, 32'h0000_0400, 32'h0);
      set_req(1, 1'b1, 1'b0, 4'b1111, 32'h0100_0800, 32'h0);
      for (int i = 0; i < 6; i++) begin
         bit k;
         k = bit'(i % 2);
         @(negedge clk_i);
         if (i == 0) begin
            chk("fp/first_stb", 32'(fp_mem_stb), 32'(1));
            chk("fp/first_is_m1", 32'(fp_mem_adr), 32'(bb_madr[1]));
         end
         chk($sformatf("bb%0d/stb", i), 32'(mem_stb_o), 32'(1));
         chk($sformatf("bb%0d/grant_adr", i), 32'(mem_adr_o), 32'(bb_madr[k]));
         mem_ack_i = 1'b1;
         mem_dat_i = 32'h5000_0000 + 32'(i);
         #1;
         chk($sformatf("bb%0d/ack", i), 32'(ack_of(k)), 32'(1));
         chk($sformatf("bb%0d/other_ack", i), 32'(ack_of(!k)), 32'(0));
         chk($sformatf("bb%0d/rdat", i), dat_of(k), 32'h5000_0000 + 32'(i));
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         chk($sformatf("bb%0d/gap", i), 32'(mem_stb_o), 32'(0));
         if (i == 4) m0_stb_i = 1'b0;
         if (i == 5) m1_stb_i = 1'b0;
      end
      @(negedge clk_i);
      chk("bb/idle_after", 32'(mem_stb_o), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_qspi_arb.md
Name: wb_qspi_arb

Overview:
- Two-master Wishbone arbiter and request sequencer in front of the single QSPI memory controller (wb_qspi_mem).
- Port m0 is the instruction fetch bus; port m1 is the data bus.
- Decodes ROM/RAM region, registers and holds the request stable for the whole QSPI transaction, and routes ack/data back to the granted master.
- Filters writes the controller cannot execute correctly (ROM-region writes, unsupported byte enables) and completes them locally without touching the QSPI bus.

Parameters:
- RAM_SEL_BIT, 24: byte-address bit selecting the region; 1 = RAM, 0 = ROM.
- ROUND_ROBIN, 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, m1 wins.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- mK_stb_i  in  1  request strobe, K in {0,1}; held until ack
- mK_we_i  in  1  write enable
- mK_be_i  in  4  byte enables
- mK_adr_i  in  32  byte address
- mK_dat_i  in  32  write data
- mK_ack_o  out  1  one-cycle completion
- mK_err_o  out  1  one-cycle error completion, coincident with ack
- mK_dat_o  out  32  read data
- mem_stb_o  out  1  to controller strobe
- mem_we_o  out  1  to controller write enable
- mem_be_o  out  4  to controller byte enables
- mem_adr_o  out  22  word address, = adr[23:2]
- mem_dat_o  out  32  to controller write data
- mem_sel_rom_ram_o  out  1  0 = ROM chip select, 1 = RAM
- mem_ack_i  in  1  controller ack
- mem_dat_i  in  32  controller read data

Behaviour:
- All downstream outputs are registered.
- Reset values: state IDLE, mem_stb_o 0, mem_we_o 0, mem_be_o 0, mem_adr_o 0, mem_dat_o 0, mem_sel_rom_ram_o 0, grant 0, last-grant 1.
- All mK_ack_o and mK_err_o are 0 during reset.
- mK_dat_o = mem_dat_i (pass-through, unregistered).
- State IDLE:
  - If no stb is high, stay in IDLE.
  - If exactly one stb is high, grant that port.
  - If both are high: with ROUND_ROBIN=1 grant the port that is not last-grant; otherwise grant m1.
  - Latch the granted port's we, be, adr, dat and sel = adr[RAM_SEL_BIT].
  - Update last-grant.
- Legality check, at grant:
  - Legal write be values: 0001, 0010, 0100, 1000, 0011, 0110, 1100, 1111.
  - Reads: every be value is legal.
  - Write with sel=0 (ROM region) -> LOCAL, err=1.
  - Write with be=0000 -> LOCAL, err=0.
  - Any other illegal write be -> LOCAL, err=1.
  - Otherwise -> XFER with mem_stb_o=1 from the next cycle.
- State XFER:
  - mem_* outputs are held constant.
  - When mem_ack_i=1: the granted port's mK_ack_o=1 in the same cycle (combinational from mem_ack_i & XFER & grant).
  - On that same edge mem_stb_o goes to 0 and state returns to IDLE, so the controller sees no strobe in its next IDLE cycle.
- State LOCAL, one cycle:
  - mK_ack_o=1 for the granted port; mK_err_o per the latched err flag.
  - Then IDLE.
- Latency:
  - Request sampled in IDLE at edge N; mem_stb_o high from N+1.
  - Completion latency = controller latency + 1 cycle.
  - LOCAL completion is 1 cycle after grant.
- The non-granted port is never acked and keeps waiting.
- A new grant is possible in the cycle after ack (back-to-back).
- mem_ack_i outside XFER is ignored; it is not forwarded.
- The controller's INIT phase needs no special handling: stb is simply held until ack.
- Asynchronous reset mid-XFER returns to IDLE immediately with mem_stb_o=0. The controller is reset by the same system reset.
- mK_stb_i dropped before ack is a protocol violation: the transaction completes anyway and the ack is still issued.
- Address bits above RAM_SEL_BIT and bits 1:0 are ignored.

Decomposition:
- Package wb_qspi_pkg holds:
  - arbiter state enum {IDLE, XFER, LOCAL};
  - the legal-write-be function;
  - the ROM/RAM select encoding constants shared with wb_qspi_mem integration.
- One sub-module, wb_arb2_rr: 2-way request grant with round-robin/fixed mode and last-grant register.
- Request latching and the FSM stay in the top module.

Test Plan:
- m0 read, adr 0x0000_0100, m1 idle -> mem_adr_o=0x040, sel=0 one cycle later; on mem_ack_i, m0_ack_o=1 and m0_dat_o=mem_dat_i; mem_stb_o=0 on the next cycle.
- m0 and m1 both request in the same cycle with ROUND_ROBIN=1, last-grant=1 -> m0 served first, m1 second; with ROUND_ROBIN=0 -> m1 served first.
- m1 write, adr 0x0100_0008, be 1111, dat 0xDEADBEEF -> sel=1, mem_adr_o=0x000002, mem_we_o=1, mem_dat_o=0xDEADBEEF; m1_ack_o=1, m1_err_o=0.
- m1 writes: ROM adr 0x0000_0010 be 1111 -> ack+err after 1 cycle, mem_stb_o never high; RAM be 0101 -> ack+err; RAM be 0000 -> ack, err=0.
- Asynchronous rst_i pulse during XFER -> mem_stb_o=0 and no ack; after release, a new m0 read completes normally.
- Back-to-back: m0 stb held continuously for 3 reads while m1 requests continuously -> grants alternate m0, m1, m0, m1, with mem_stb_o low for at least 1 cycle between transactions.
